// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver: scans digits 3..0, blanks each
// slot briefly so the external digit mux can settle, and latches the digit per slot.
module seg_scan_driver #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic [3:0] dp_en,
    input  logic       lz_blank,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LATCH = CW'(BLANK_CYCLES - 1);
    // frame is registered, so it is armed one cycle before the slot's last count
    localparam logic [CW-1:0] CNT_FRAME = CW'(DIGIT_CYCLES - 2);

    typedef enum logic {BLANK, ON} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    sel_reg;
    logic [3:0]    digit_reg;
    logic          dp_lat_reg;
    logic          lz_reg;
    logic          nz_reg;
    logic [3:0]    an_reg, an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg, dp_next;
    logic          frame_reg;
    logic          suppress;

    function automatic logic [6:0] hex_decode(input logic [3:0] d);
        case (d)
            4'h0: hex_decode = 7'h40;
            4'h1: hex_decode = 7'h79;
            4'h2: hex_decode = 7'h24;
            4'h3: hex_decode = 7'h30;
            4'h4: hex_decode = 7'h19;
            4'h5: hex_decode = 7'h12;
            4'h6: hex_decode = 7'h02;
            4'h7: hex_decode = 7'h78;
            4'h8: hex_decode = 7'h00;
            4'h9: hex_decode = 7'h10;
            4'hA: hex_decode = 7'h08;
            4'hB: hex_decode = 7'h03;
            4'hC: hex_decode = 7'h46;
            4'hD: hex_decode = 7'h21;
            4'hE: hex_decode = 7'h06;
            default: hex_decode = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= BLANK;
        end else begin
            state_reg <= state_next;
        end
    end

    // Leading zeros stay dark until the first nonzero digit of this frame; digit 0 always shows
    assign suppress = lz_reg && (sel_reg != 2'd0) && !nz_reg && (digit_reg == 4'h0);

    always_comb begin
        state_next = state_reg;
        an_next    = 4'b1111;
        seg_next   = 7'b1111111;
        dp_next    = 1'b1;
        case (state_reg)
            BLANK: if (cnt_reg == CNT_LATCH) state_next = ON;
            ON:    if (cnt_reg == CNT_LAST)  state_next = BLANK;
            default: state_next = BLANK;
        endcase
        if (state_reg == ON && !suppress) begin
            an_next  = ~(4'b0001 << sel_reg);
            seg_next = hex_decode(digit_reg);
            dp_next  = ~dp_lat_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            sel_reg    <= 2'd3;
            digit_reg  <= 4'h0;
            dp_lat_reg <= 1'b0;
            lz_reg     <= 1'b0;
            nz_reg     <= 1'b0;
            an_reg     <= 4'b1111;
            seg_reg    <= 7'b1111111;
            dp_reg     <= 1'b1;
            frame_reg  <= 1'b0;
        end else begin
            if (cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
                sel_reg <= sel_reg - 2'd1;
                if (sel_reg == 2'd0) nz_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (cnt_reg == CNT_LATCH) begin
                digit_reg  <= digit;
                dp_lat_reg <= dp_en[sel_reg];
                lz_reg     <= lz_blank;
                if (digit != 4'h0) nz_reg <= 1'b1;
            end
            an_reg    <= an_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
            frame_reg <= (cnt_reg == CNT_FRAME) && (sel_reg == 2'd0);
        end
    end

    assign sel   = sel_reg;
    assign an    = an_reg;
    assign seg   = seg_reg;
    assign dp    = dp_reg;
    assign frame = frame_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (DIGIT_CYCLES=8, BLANK_CYCLES=2): a slot/position model
// checked every cycle, plus literal expectations at chosen scan positions.
module tb_seg_scan_driver;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int HN = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit;
    logic [3:0] dp_en = 4'b0000;
    logic       lz_blank = 1'b0;
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    logic [3:0] digs [4];
    logic [15:0] hist_digs [HN];
    logic [3:0]  hist_dp [HN];
    logic        hist_lz [HN];
    logic [6:0]  dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int p = 0;
    int n_tests = 0;
    int n_fail = 0;

    assign digit = digs[sel];

    seg_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .digit(digit), .dp_en(dp_en), .lz_blank(lz_blank),
        .sel(sel), .an(an), .seg(seg), .dp(dp), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at pos %0d: got %h required %h", nm, p, got, exp);
        end
    endtask

    // Position = clock edges since reset release; record inputs seen at each edge
    always @(posedge clk) begin
        if (rst) begin
            p = 0;
        end else begin
            if (p < HN) begin
                hist_digs[p] = {digs[3], digs[2], digs[1], digs[0]};
                hist_dp[p]   = dp_en;
                hist_lz[p]   = lz_blank;
            end
            p = p + 1;
        end
    end

    // Expected {sel, an, seg, dp, frame} at position q from slot arithmetic
    function automatic logic [14:0] model(input int q);
        int s, c, ds, lp, fs;
        logic [1:0] esel, dsel;
        logic [3:0] d, ean;
        logic [6:0] eseg;
        logic edp, efr, nz, dark;
        esel = 2'(3 - ((q / DC) % 4));
        efr  = ((q % DC) == DC - 1) && (((q / DC) % 4) == 3);
        ean  = 4'b1111;
        eseg = 7'h7F;
        edp  = 1'b1;
        if (q >= 1) begin
            s = (q - 1) / DC;
            c = (q - 1) % DC;
            if (c >= BC) begin
                dsel = 2'(3 - (s % 4));
                lp   = s * DC + BC - 1;
                d    = hist_digs[lp][dsel*4 +: 4];
                nz   = 1'b0;
                fs   = s - (s % 4);
                for (int k = fs; k < s; k++) begin
                    ds = 3 - (k % 4);
                    if (hist_digs[k*DC + BC - 1][ds*4 +: 4] != 4'h0) nz = 1'b1;
                end
                dark = hist_lz[lp] && (dsel != 2'd0) && !nz && (d == 4'h0);
                if (!dark) begin
                    ean  = ~(4'b0001 << dsel);
                    eseg = dec_tab[d];
                    edp  = ~hist_dp[lp][dsel];
                end
            end
        end
        return {esel, ean, eseg, edp, efr};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", {1'b0, sel, an, seg, dp, frame}, {1'b0, 2'd3, 4'hF, 7'h7F, 1'b1, 1'b0});
        end else if (p < HN) begin
            chk("scan_model", {1'b0, sel, an, seg, dp, frame}, {1'b0, model(p)});
        end
    end

    task automatic wait_pos(input int n);
        int budget = 0;
        while (p != n && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        n_tests++;
        if (p != n) begin
            n_fail++;
            $display("FAIL wait_pos: got pos %0d required %0d", p, n);
        end
    endtask

    task automatic set_digs(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
        digs[3] = d3; digs[2] = d2; digs[1] = d1; digs[0] = d0;
    endtask

    initial begin
        set_digs(4'h1, 4'h2, 4'h3, 4'h4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // plain scan 1,2,3,4
        wait_pos(0);  chk("sel_start", 16'(sel), 16'd3);
        wait_pos(2);  chk("an_blank_p2", 16'(an), 16'hF);
        wait_pos(3);  chk("an_first_on", 16'(an), 16'b0111); chk("seg_d3", 16'(seg), 16'h79);
        wait_pos(8);  chk("sel_p8", 16'(sel), 16'd2);
        wait_pos(11); chk("an_d2", 16'(an), 16'b1011); chk("seg_d2", 16'(seg), 16'h24);
        wait_pos(19); chk("seg_d1", 16'(seg), 16'h30);
        wait_pos(27); chk("seg_d0", 16'(seg), 16'h19);
        wait_pos(30); chk("frame_p30", 16'(frame), 16'd0);
        wait_pos(31); chk("frame_p31", 16'(frame), 16'd1);
        // leading-zero blanking 0,0,4,0
        wait_pos(32); set_digs(4'h0, 4'h0, 4'h4, 4'h0); lz_blank = 1'b1;
        wait_pos(35); chk("lz_d3_dark", 16'(an), 16'hF);
        wait_pos(43); chk("lz_d2_dark", 16'({an, seg}), {5'd0, 4'hF, 7'h7F});
        wait_pos(51); chk("lz_d1_lit", 16'({an, seg}), {5'd0, 4'b1101, 7'h19});
        wait_pos(59); chk("lz_d0_zero", 16'({an, seg}), {5'd0, 4'b1110, 7'h40});
        // all zeros: only digit 0 lit
        wait_pos(64); set_digs(4'h0, 4'h0, 4'h0, 4'h0);
        wait_pos(75); chk("zero_d2_dark", 16'(an), 16'hF);
        wait_pos(83); chk("zero_d1_dark", 16'(an), 16'hF);
        wait_pos(91); chk("zero_d0_lit", 16'({an, seg}), {5'd0, 4'b1110, 7'h40});
        // decimal point on digit 2 only
        wait_pos(96); set_digs(4'h1, 4'h2, 4'h3, 4'h4); lz_blank = 1'b0; dp_en = 4'b0100;
        wait_pos(99);  chk("dp_d3_off", 16'(dp), 16'd1);
        wait_pos(105); chk("dp_d2_blank", 16'(dp), 16'd1);
        wait_pos(107); chk("dp_d2_on", 16'({an, dp}), {11'd0, 4'b1011, 1'b0});
        wait_pos(115); chk("dp_d1_off", 16'(dp), 16'd1);
        // digit change mid-ON must not reach seg until the next latch
        wait_pos(128); dp_en = 4'b0000;
        wait_pos(133); digs[3] = 4'h8;
        wait_pos(136); chk("latch_hold", 16'(seg), 16'h79);
        wait_pos(163); chk("latch_next", 16'(seg), 16'h00);
        // reset at cnt=5 of the sel=1 slot blanks at once
        wait_pos(181);
        #1 rst = 1'b1;
        #1 chk("async_rst", 16'({an, seg, dp}), {4'd0, 4'hF, 7'h7F, 1'b1});
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_sel", 16'(sel), 16'd3);
        wait_pos(3);  chk("restart_on", 16'({an, seg}), {5'd0, 4'b0111, 7'h00});
        wait_pos(40);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter DIGIT_CYCLES, default 50000, clock cycles per digit slot (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 500, leading blank cycles per slot; legal range 1 <= BLANK_CYCLES <= DIGIT_CYCLES-2.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port digit, input, 4 bits, hex value of the digit currently addressed by sel, returned by the external 4:1 digit mux.
REQ-006 The block SHALL have port dp_en, input, 4 bits, per-digit decimal-point enable indexed by digit position.
REQ-007 The block SHALL have port lz_blank, input, 1 bit, leading-zero blanking enable.
REQ-008 The block SHALL have port sel, output, 2 bits, digit address that drives the external mux select.
REQ-009 The block SHALL have port an, output, 4 bits, active-low one-hot anode enables, bit i = digit i.
REQ-010 The block SHALL have port seg, output, 7 bits, active-low segments {g,f,e,d,c,b,a}.
REQ-011 The block SHALL have port dp, output, 1 bit, active-low decimal point.
REQ-012 The block SHALL have port frame, output, 1 bit, one-cycle pulse at the end of each full 4-digit scan.

Function
REQ-013 The block SHALL count slot cycles 0..DIGIT_CYCLES-1 in a counter of width clog2(DIGIT_CYCLES), wrapping to 0 and advancing sel at the wrap.
REQ-014 The block SHALL scan sel in order 3,2,1,0,3,... (most significant first).
REQ-015 Two states SHALL be used: BLANK (cnt 0..BLANK_CYCLES-1) and ON (cnt BLANK_CYCLES..DIGIT_CYCLES-1); BLANK->ON at cnt==BLANK_CYCLES-1, ON->BLANK at cnt==DIGIT_CYCLES-1.
REQ-016 During BLANK, outputs SHALL be an=4'b1111, seg=7'b1111111, dp=1; sel SHALL already hold the new address so the mux output settles.
REQ-017 The block SHALL register digit into an internal latch on the cycle cnt==BLANK_CYCLES-1; that latched value SHALL be displayed for the whole ON phase regardless of later digit changes.
REQ-018 During ON, an SHALL have only bit sel low, seg SHALL be the hex decode of the latched digit, and dp SHALL be ~dp_en[sel] sampled with the digit.
REQ-019 Decode (seg hex) SHALL be 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-020 All outputs SHALL be registered; an/seg/dp change one cycle after the counter reaches the phase boundary, never glitching between.
REQ-021 A nonzero_seen flag SHALL clear when the sel=3 slot begins and SHALL set when a nonzero digit is latched.
REQ-022 When lz_blank=1, sel!=0, nonzero_seen=0 and the latched digit is 0, the ON phase SHALL keep an=1111, seg=1111111, dp=1; digit 0 SHALL never be blanked.
REQ-023 frame SHALL pulse high for exactly one cycle when cnt==DIGIT_CYCLES-1 and sel==0.
REQ-024 A change of lz_blank or dp_en SHALL take effect at the next latch point only.

Reset
REQ-025 While rst=1, the block SHALL immediately force sel=3, an=1111, seg=1111111, dp=1, frame=0, cnt=0, state BLANK, latched digit=0, nonzero_seen=0.
REQ-026 After rst deasserts, the first slot SHALL be a complete sel=3 slot starting at cnt=0; assertion mid-ON SHALL blank the display in the same cycle, with no partial slot resumed.

Verification (DIGIT_CYCLES=8, BLANK_CYCLES=2, bench models the mux from sel)
REQ-027 Reset: assert rst for 3 cycles then release -> outputs at REQ-025 values during reset; an first goes 0111 at cycle 3 after release.
REQ-028 Scan: digits d3..d0=1,2,3,4, lz_blank=0 -> sel sequence 3,2,1,0 each 8 cycles; an low 6 cycles per slot; seg 79,24,30,19; frame every 32 cycles.
REQ-029 Leading zero: d3..d0=0,0,4,0, lz_blank=1 -> slots 3 and 2 fully dark, slot 1 seg=19, slot 0 seg=40; all-zero digits -> only digit 0 lit with seg=40.
REQ-030 Decimal point: dp_en=4'b0100 -> dp=0 only during the ON phase of the sel=2 slot, 1 elsewhere.
REQ-031 Latch stability: change digit mid-ON -> seg unchanged until the next slot.
REQ-032 Mid-slot reset: assert rst at cnt=5 of the sel=1 slot -> an=1111 in the same cycle; after release the scan restarts at sel=3.
